// File: rtl/spio_uart_rx_framer.sv
// UART receive framer: oversampled 8N1 recovery into a single-entry valid/ready register.
// Define SPIO_UART_RX_PARITY_EN for 8E1 framing with a parity-error pulse.
`timescale 1ns/1ps

module spio_uart_rx_framer #(
  parameter int   TICKS_PER_BIT = 16,
  parameter logic IDLE_VALUE    = 1'b1
) (
  input  logic       CLK_IN,
  input  logic       RESET_IN,
  input  logic       RX_IN,
  input  logic       SAMPLE_TICK_IN,
  output logic [7:0] DATA_OUT,
  output logic       VLD_OUT,
  input  logic       RDY_IN,
  output logic       FRAMING_ERR_OUT,
  output logic       OVERRUN_OUT,
  output logic       PARITY_ERR_OUT
);

  localparam int            CW       = $clog2(TICKS_PER_BIT);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_MID  = CW'(TICKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } state_t;

`ifdef SPIO_UART_RX_PARITY_EN
  localparam state_t ST_AFTER_DATA = ST_PARITY;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

  logic par_bad_r, par_bad_s;
  logic par_err_r, par_err_s;
`else
  localparam state_t ST_AFTER_DATA = ST_STOP;
`endif

  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [2:0]    bit_r, bit_s;
  logic [7:0]    shift_r, shift_s;
  logic          new_byte_r, new_byte_s;
  logic          frame_err_r, frame_err_s;
  logic          rx_idle_s;

  // Mark level is logic 1 in the recovered byte regardless of line polarity.
  assign rx_idle_s = (RX_IN == IDLE_VALUE);

  // Next-state and sample logic; everything advances only on sample ticks.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    bit_s       = bit_r;
    shift_s     = shift_r;
    new_byte_s  = 1'b0;
    frame_err_s = 1'b0;
`ifdef SPIO_UART_RX_PARITY_EN
    par_bad_s   = par_bad_r;
    par_err_s   = 1'b0;
`endif
    if (SAMPLE_TICK_IN) begin
      case (state_r)
        ST_IDLE: begin
          if (!rx_idle_s) begin
            state_s = ST_START;
            cnt_s   = CNT_ONE;
          end else begin
            cnt_s   = CNT_ZERO;
          end
        end
        ST_START: begin
          if (cnt_r == CNT_MID) begin
            cnt_s = CNT_ZERO;
            bit_s = 3'd0;
            if (rx_idle_s) begin
              state_s = ST_IDLE;
            end else begin
              state_s = ST_DATA;
            end
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end
        ST_DATA: begin
          if (cnt_r == CNT_LAST) begin
            cnt_s   = CNT_ZERO;
            shift_s = {rx_idle_s, shift_r[7:1]};
            if (bit_r == 3'd7) begin
              state_s = ST_AFTER_DATA;
            end else begin
              bit_s = bit_r + 3'd1;
            end
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end
`ifdef SPIO_UART_RX_PARITY_EN
        ST_PARITY: begin
          if (cnt_r == CNT_LAST) begin
            cnt_s     = CNT_ZERO;
            par_bad_s = rx_idle_s ^ even_parity(shift_r);
            state_s   = ST_STOP;
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end
`endif
        ST_STOP: begin
          if (cnt_r == CNT_LAST) begin
            cnt_s = CNT_ZERO;
`ifdef SPIO_UART_RX_PARITY_EN
            par_err_s = par_bad_r;
`endif
            if (rx_idle_s) begin
              state_s = ST_IDLE;
`ifdef SPIO_UART_RX_PARITY_EN
              new_byte_s = !par_bad_r;
`else
              new_byte_s = 1'b1;
`endif
            end else begin
              state_s     = ST_WAIT_IDLE;
              frame_err_s = 1'b1;
            end
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end
        ST_WAIT_IDLE: begin
          if (rx_idle_s) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_WAIT_IDLE;
          end
        end
        default: begin
          state_s = ST_IDLE;
          cnt_s   = CNT_ZERO;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Framer state, counters and one-cycle decision pulses.
  always_ff @(posedge CLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      state_r     <= ST_IDLE;
      cnt_r       <= CNT_ZERO;
      bit_r       <= 3'd0;
      shift_r     <= 8'h00;
      new_byte_r  <= 1'b0;
      frame_err_r <= 1'b0;
`ifdef SPIO_UART_RX_PARITY_EN
      par_bad_r   <= 1'b0;
      par_err_r   <= 1'b0;
`endif
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      bit_r       <= bit_s;
      shift_r     <= shift_s;
      new_byte_r  <= new_byte_s;
      frame_err_r <= frame_err_s;
`ifdef SPIO_UART_RX_PARITY_EN
      par_bad_r   <= par_bad_s;
      par_err_r   <= par_err_s;
`endif
    end
  end

  // Output register: shift_r still holds the byte the cycle after the stop sample.
  always_ff @(posedge CLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      DATA_OUT    <= 8'h00;
      VLD_OUT     <= 1'b0;
      OVERRUN_OUT <= 1'b0;
    end else begin
      OVERRUN_OUT <= 1'b0;
      if (new_byte_r) begin
        if (!VLD_OUT || RDY_IN) begin
          DATA_OUT <= shift_r;
          VLD_OUT  <= 1'b1;
        end else begin
          OVERRUN_OUT <= 1'b1;
        end
      end else if (VLD_OUT && RDY_IN) begin
        VLD_OUT <= 1'b0;
      end else begin
        VLD_OUT <= VLD_OUT;
      end
    end
  end

  assign FRAMING_ERR_OUT = frame_err_r;
`ifdef SPIO_UART_RX_PARITY_EN
  assign PARITY_ERR_OUT  = par_err_r;
`else
  assign PARITY_ERR_OUT  = 1'b0;
`endif

endmodule
